// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: default geometry,
// timeout limit, FSM state encoding and requester identifiers.
package dm_pkg;

    localparam int DM_AW      = 7;
    localparam int DM_DW      = 32;
    localparam int DM_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_L = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. req[0] is the processor, req[1] the
// loader. On a tie the requester that was not granted last wins.
module rr_arbiter2
    import dm_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant = REQ_P;
        case (req)
            2'b01:   grant = REQ_P;
            2'b10:   grant = REQ_L;
            2'b11:   grant = (last_grant == REQ_P) ? REQ_L : REQ_P;
            default: grant = REQ_P;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the processor MEM-stage port and the loader/debug port onto a
// single data-memory port. One access in flight at a time, with a bounded
// ACCESS phase that aborts and flags err if the memory never answers.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int AW      = DM_AW,
    parameter int DW      = DM_DW,
    parameter int TIMEOUT = DM_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic [DW-1:0] p_rdata,
    output logic          p_ack,

    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_ack,

    output logic          dm_ena,
    output logic          dm_wea,
    output logic [AW-1:0] dm_addra,
    output logic [DW-1:0] dm_dina,
    input  logic [DW-1:0] dm_douta,
    input  logic          dm_done,

    output logic          busy,
    output logic          err
);

    // Counter is wide enough to hold TIMEOUT itself.
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    req_id_t       last_grant_q, last_grant_d;
    req_id_t       winner_q, winner_d;
    req_id_t       pick;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] p_rdata_q, p_rdata_d;
    logic [DW-1:0] l_rdata_q, l_rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout_hit;

    rr_arbiter2 u_rr (
        .req        ({l_req, p_req}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    // True in the ACCESS cycle that would be the TIMEOUT-th one.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic: grant in IDLE, wait for done or timeout in ACCESS.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        p_rdata_d    = p_rdata_q;
        l_rdata_d    = l_rdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (p_req || l_req) begin
                    winner_d     = pick;
                    last_grant_d = pick;
                    if (pick == REQ_P) begin
                        we_d    = p_we;
                        addr_d  = p_addr;
                        wdata_d = p_wdata;
                    end else begin
                        we_d    = l_we;
                        addr_d  = l_addr;
                        wdata_d = l_wdata;
                    end
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // done wins over a timeout landing in the same cycle
                if (dm_done) begin
                    state_d = ACK;
                    if (!we_q) begin
                        if (winner_q == REQ_P) p_rdata_d = dm_douta;
                        else                   l_rdata_d = dm_douta;
                    end
                end else if (timeout_hit) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                    if (winner_q == REQ_P) p_rdata_d = '0;
                    else                   l_rdata_d = '0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset makes the processor win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_L;
            winner_q     <= REQ_P;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p_rdata_q    <= '0;
            l_rdata_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            p_rdata_q    <= p_rdata_d;
            l_rdata_q    <= l_rdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Memory side is driven straight from the latched request.
    assign dm_ena   = (state_q == ACCESS);
    assign dm_wea   = dm_ena & we_q;
    assign dm_addra = addr_q;
    assign dm_dina  = wdata_q;

    assign p_ack    = (state_q == ACK) && (winner_q == REQ_P);
    assign l_ack    = (state_q == ACK) && (winner_q == REQ_L);
    assign p_rdata  = p_rdata_q;
    assign l_rdata  = l_rdata_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios, a bench-side memory responder,
// a timeline model checked every cycle, and literal expectations per scenario.
module tb_dm_arbiter;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_req, p_we, l_req, l_we;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata, p_rdata, l_rdata;
    logic          p_ack, l_ack;
    logic          dm_ena, dm_wea;
    logic [AW-1:0] dm_addra;
    logic [DW-1:0] dm_dina;
    logic [DW-1:0] dm_douta = '0;
    logic          dm_done  = 1'b0;
    logic          busy, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Responder configuration: lat = ACCESS cycles up to and including done
    // (0 means the memory never answers).
    int          lat_cfg    = 2;
    logic [31:0] rd_val_cfg = '0;
    bit          stray_done = 1'b0;

    dm_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_ack(l_ack),
        .dm_ena(dm_ena), .dm_wea(dm_wea), .dm_addra(dm_addra), .dm_dina(dm_dina),
        .dm_douta(dm_douta), .dm_done(dm_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: counts consecutive enabled cycles, answers on the lat-th.
    int ena_cnt = 0;
    always @(negedge clk) begin
        if (dm_ena) ena_cnt++;
        else        ena_cnt = 0;
        dm_done  = stray_done || (lat_cfg != 0 && dm_ena && ena_cnt == lat_cfg);
        dm_douta = rd_val_cfg;
    end

    // Activity monitor used by the literal checks.
    int          ena_run = 0, low_run = 0, last_len = 0, gap_last = 0;
    bit          ena_prev = 1'b0;
    int          p_ack_cnt = 0, l_ack_cnt = 0;
    int          ack_log[$];
    logic [6:0]  addr_log[$];
    always @(negedge clk) begin
        if (dm_ena) begin
            if (!ena_prev) begin
                addr_log.push_back(dm_addra);
                gap_last = low_run;
            end
            ena_run++;
            low_run = 0;
        end else begin
            if (ena_prev) last_len = ena_run;
            ena_run = 0;
            low_run++;
        end
        ena_prev = dm_ena;
        if (p_ack) begin p_ack_cnt++; ack_log.push_back(0); end
        if (l_ack) begin l_ack_cnt++; ack_log.push_back(1); end
    end

    // Timeline model: a grant decided in an idle cycle c occupies ACCESS
    // cycles c+1..c+L, acks at c+L+1 and is free again at c+L+2.
    int          cyc = 0;
    bit          sv = 1'b0;
    int          a_s = 0, a_e = 0, k_c = 0;
    int          m_win = 0, m_last = 1;
    logic        m_we = 1'b0, m_to = 1'b0;
    logic [6:0]  m_addr = '0;
    logic [31:0] m_wd = '0, m_rd = '0, m_prd = '0, m_lrd = '0;
    logic        m_err = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            sv = 1'b0; m_last = 1; m_prd = '0; m_lrd = '0; m_err = 1'b0;
            chk("rst_dm_ena", dm_ena, 0);   chk("rst_busy", busy, 0);
            chk("rst_p_ack", p_ack, 0);     chk("rst_l_ack", l_ack, 0);
            chk("rst_p_rdata", p_rdata, 0); chk("rst_l_rdata", l_rdata, 0);
            chk("rst_err", err, 0);         chk("rst_dm_wea", dm_wea, 0);
            chk("rst_dm_addra", dm_addra, 0); chk("rst_dm_dina", dm_dina, 0);
        end else begin
            bit in_acc, in_ack;
            if (sv && cyc == k_c) begin
                if (m_to) begin
                    m_err = 1'b1;
                    if (m_win == 0) m_prd = '0; else m_lrd = '0;
                end else if (!m_we) begin
                    if (m_win == 0) m_prd = m_rd; else m_lrd = m_rd;
                end
            end
            in_acc = sv && cyc >= a_s && cyc <= a_e;
            in_ack = sv && cyc == k_c;
            chk("m_dm_ena", dm_ena, in_acc);
            chk("m_busy", busy, in_acc || in_ack);
            chk("m_p_ack", p_ack, in_ack && m_win == 0);
            chk("m_l_ack", l_ack, in_ack && m_win == 1);
            chk("m_p_rdata", p_rdata, m_prd);
            chk("m_l_rdata", l_rdata, m_lrd);
            chk("m_err", err, m_err);
            if (in_acc) begin
                chk("m_dm_wea", dm_wea, m_we);
                chk("m_dm_addra", dm_addra, m_addr);
                chk("m_dm_dina", dm_dina, m_wd);
            end
            if ((!sv || cyc > k_c) && (p_req || l_req)) begin
                int lat;
                if (p_req && l_req) m_win = (m_last == 0) ? 1 : 0;
                else                m_win = p_req ? 0 : 1;
                m_last = m_win;
                m_we   = (m_win == 0) ? p_we : l_we;
                m_addr = (m_win == 0) ? p_addr : l_addr;
                m_wd   = (m_win == 0) ? p_wdata : l_wdata;
                m_rd   = rd_val_cfg;
                lat    = lat_cfg;
                m_to   = (lat == 0 || lat > TMO);
                if (m_to) lat = TMO;
                sv  = 1'b1;
                a_s = cyc + 1;
                a_e = cyc + lat;
                k_c = cyc + lat + 1;
            end
        end
    end

    // which: 0 = p_ack, 1 = l_ack, 2 = dm_ena
    task automatic wait_for(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            case (which)
                0:       seen = p_ack;
                1:       seen = l_ack;
                default: seen = dm_ena;
            endcase
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int pa0, la0, n, sz;
        rst = 1'b1;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        #1 rst = 1'b0;
        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_dm_ena", dm_ena, 0);
        chk("reset_err", err, 0);
        chk("reset_p_rdata", p_rdata, 0);
        rst = 1'b1;
        tick();

        // Simultaneous writes after reset: processor first, then loader.
        lat_cfg = 2;
        p_req = 1; p_we = 1; p_addr = 7'h10; p_wdata = 32'h1;
        l_req = 1; l_we = 1; l_addr = 7'h11; l_wdata = 32'h2;
        wait_for(0, "tie_p_ack_seen");
        p_req = 0;
        wait_for(1, "tie_l_ack_seen");
        l_req = 0;
        tick();
        sz = addr_log.size();
        chk("tie_first_addr", addr_log[sz-2], 7'h10);
        chk("tie_second_addr", addr_log[sz-1], 7'h11);
        chk("tie_ena_gap", gap_last, 2);
        chk("tie_ack_order_p", ack_log[ack_log.size()-2], 0);
        chk("tie_ack_order_l", ack_log[ack_log.size()-1], 1);

        // Both hold req for six grants: strict alternation starting with P.
        lat_cfg = 1; rd_val_cfg = 32'h12345678;
        p_req = 1; p_we = 0; p_addr = 7'h20;
        l_req = 1; l_we = 0; l_addr = 7'h21;
        n = 0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            tick();
            if (p_ack || l_ack) n++;
        end
        chk("alt_six_grants", n, 6);
        p_req = 0; l_req = 0;
        tick();
        sz = ack_log.size();
        for (int j = 0; j < 6; j++) chk("alt_order", ack_log[sz-6+j], j % 2);

        // Processor read at 05, done two cycles after enable.
        lat_cfg = 3; rd_val_cfg = 32'hDEADBEEF;
        pa0 = p_ack_cnt; la0 = l_ack_cnt;
        p_req = 1; p_we = 0; p_addr = 7'h05;
        tick();
        p_addr = 7'h33;   // ignored: fields were latched at grant
        wait_for(0, "rd_p_ack_seen");
        p_req = 0;
        tick();
        chk("rd_p_rdata", p_rdata, 32'hDEADBEEF);
        chk("rd_access_len", last_len, 3);
        chk("rd_addr", addr_log[addr_log.size()-1], 7'h05);
        chk("rd_p_ack_pulses", p_ack_cnt - pa0, 1);
        chk("rd_l_ack_pulses", l_ack_cnt - la0, 0);

        // Stray done in IDLE, then a write to 7F.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_busy", busy, 0);
        lat_cfg = 2;
        p_req = 1; p_we = 1; p_addr = 7'h7F; p_wdata = 32'hA5A5A5A5;
        wait_for(0, "wr_p_ack_seen");
        p_req = 0;
        tick();
        chk("wr_p_rdata_kept", p_rdata, 32'hDEADBEEF);
        chk("wr_addr", addr_log[addr_log.size()-1], 7'h7F);
        chk("wr_access_len", last_len, 2);

        // Loader read that never completes: timeout after 15 cycles.
        lat_cfg = 0;
        l_req = 1; l_we = 0; l_addr = 7'h03;
        wait_for(1, "to_l_ack_seen");
        l_req = 0;
        tick();
        chk("to_access_len", last_len, 15);
        chk("to_l_rdata", l_rdata, 0);
        chk("to_err", err, 1);

        // err stays set through a normal access.
        lat_cfg = 2; rd_val_cfg = 32'hCAFEF00D;
        p_req = 1; p_we = 0; p_addr = 7'h40;
        wait_for(0, "sticky_p_ack_seen");
        p_req = 0;
        tick();
        chk("sticky_err", err, 1);
        chk("sticky_p_rdata", p_rdata, 32'hCAFEF00D);

        // Reset in the middle of an access.
        lat_cfg = 0;
        pa0 = p_ack_cnt;
        p_req = 1; p_we = 0; p_addr = 7'h0A;
        wait_for(2, "mid_ena_seen");
        tick();
        #2 rst = 1'b0;
        #1;
        chk("mid_dm_ena", dm_ena, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_p_rdata", p_rdata, 0);
        chk("mid_dm_addra", dm_addra, 0);
        p_req = 0;
        tick(); tick();
        chk("mid_no_ack", p_ack_cnt - pa0, 0);
        rst = 1'b1;
        tick();

        // After reset the processor wins the first tie again.
        lat_cfg = 1;
        p_req = 1; p_we = 1; p_addr = 7'h01; p_wdata = 32'h11;
        l_req = 1; l_we = 1; l_addr = 7'h02; l_wdata = 32'h22;
        wait_for(0, "post_p_ack_seen");
        p_req = 0;
        wait_for(1, "post_l_ack_seen");
        l_req = 0;
        tick(); tick();
        chk("post_first_addr", addr_log[addr_log.size()-2], 7'h01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d passed of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
